// File: rtl/reset_release_gather.sv
// Releases N branch resets in a fixed staggered order and gathers their acknowledgements.
// Reports done when every branch has acked, or flags a timeout and re-asserts all resets.
module reset_release_gather #(
    parameter int N       = 5,
    parameter int STAGGER = 4,
    parameter int TIMEOUT = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] branch_ack,
    output logic [N-1:0] branch_reset,
    output logic         done,
    output logic         timeout_err,
    output logic [N-1:0] pending
);

    localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [N-1:0]   branch_reset_q, branch_reset_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           done_q, done_d;
    logic           timeout_err_q, timeout_err_d;
    logic [N-1:0]   ack_hit_s;
    logic [N-1:0]   pending_acked_s;

    // Only acks from branches already out of reset (as seen before the edge) count.
    assign ack_hit_s       = ~branch_reset_q & branch_ack;
    assign pending_acked_s = pending_q & ~ack_hit_s;

    // Next-state and output computation for the release sequencer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        branch_reset_d = branch_reset_q;
        pending_d      = pending_q;
        done_d         = done_q;
        timeout_err_d  = timeout_err_q;

        if (abort) begin
            state_d        = S_HOLD;
            idx_d          = {IW{1'b0}};
            cnt_d          = {CW{1'b0}};
            timer_d        = {TW{1'b0}};
            branch_reset_d = {N{1'b1}};
            pending_d      = {N{1'b1}};
            done_d         = 1'b0;
            timeout_err_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (start) begin
                        state_d = S_RELEASE;
                        idx_d   = {IW{1'b0}};
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_RELEASE: begin
                    pending_d = pending_acked_s;
                    if (cnt_q == CW'(STAGGER - 1)) begin
                        cnt_d = {CW{1'b0}};
                        for (int i = 0; i < N; i++) begin
                            branch_reset_d[i] = (idx_q == IW'(i)) ? 1'b0 : branch_reset_q[i];
                        end
                        if (idx_q == IW'(N - 1)) begin
                            state_d = S_WAIT;
                            idx_d   = {IW{1'b0}};
                            timer_d = {TW{1'b0}};
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    pending_d = pending_acked_s;
                    timer_d   = timer_q + TW'(1);
                    // Completion is tested first so a last ack on the timeout edge still wins.
                    if (pending_acked_s == {N{1'b0}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        timer_d = {TW{1'b0}};
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d        = S_ERR;
                        timeout_err_d  = 1'b1;
                        branch_reset_d = {N{1'b1}};
                        timer_d        = {TW{1'b0}};
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d        = S_HOLD;
                    idx_d          = {IW{1'b0}};
                    cnt_d          = {CW{1'b0}};
                    timer_d        = {TW{1'b0}};
                    branch_reset_d = {N{1'b1}};
                    pending_d      = {N{1'b1}};
                    done_d         = 1'b0;
                    timeout_err_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset puts every branch back into reset immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_HOLD;
            idx_q          <= {IW{1'b0}};
            cnt_q          <= {CW{1'b0}};
            timer_q        <= {TW{1'b0}};
            branch_reset_q <= {N{1'b1}};
            pending_q      <= {N{1'b1}};
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            branch_reset_q <= branch_reset_d;
            pending_q      <= pending_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign branch_reset = branch_reset_q;
    assign done         = done_q;
    assign timeout_err  = timeout_err_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_reset_release_gather.sv
// Randomized and directed bench for reset_release_gather against a time-based reference model.
module tb_reset_release_gather;

    localparam int N = 5;
    localparam int S = 4;
    localparam int T = 256;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] branch_ack = '0;
    logic [N-1:0] branch_reset;
    logic         done;
    logic         timeout_err;
    logic [N-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    reset_release_gather #(.N(N), .STAGGER(S), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .branch_ack(branch_ack), .branch_reset(branch_reset), .done(done),
        .timeout_err(timeout_err), .pending(pending)
    );

    always #5 clock = ~clock;

    // Compare one observed value with its expectation and tally the result.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 sequencing, 2 done, 3 error; t counts edges since start.
    int           m_mode = 0;
    int           m_t    = 0;
    logic [N-1:0] m_pend = '1;

    function automatic logic [N-1:0] m_br();
        logic [N-1:0] r;
        r = '1;
        if (m_mode == 1 || m_mode == 2)
            for (int i = 0; i < N; i++) r[i] = (m_t < (i + 1) * S);
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [N-1:0] br_pre;
        if (!reset) begin
            m_mode = 0; m_t = 0; m_pend = '1;
        end else begin
            br_pre = m_br();
            if (abort) begin
                m_mode = 0; m_t = 0; m_pend = '1;
            end else if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_t = 0; end
            end else if (m_mode == 1) begin
                for (int i = 0; i < N; i++)
                    if (!br_pre[i] && branch_ack[i]) m_pend[i] = 1'b0;
                if (m_t >= N * S) begin
                    if (m_pend == '0) m_mode = 2;
                    else if (m_t - N * S == T - 1) m_mode = 3;
                end
                m_t++;
            end
        end
    end

    // Every cycle, compare all outputs with the model away from the active edge.
    always @(negedge clock) begin
        check_val("branch_reset", branch_reset, m_br());
        check_val("done", done, m_mode == 2);
        check_val("timeout_err", timeout_err, m_mode == 3);
        check_val("pending", pending, m_pend);
    end

    int ec = 0;
    always @(posedge clock) ec++;

    int start_edge, done_edge, err_edge;
    int fall_edge[N];

    task automatic clear_marks();
        done_edge = -1; err_edge = -1;
        for (int i = 0; i < N; i++) fall_edge[i] = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            if (done && done_edge < 0) done_edge = ec;
            if (timeout_err && err_edge < 0) err_edge = ec;
            for (int i = 0; i < N; i++)
                if (!branch_reset[i] && fall_edge[i] < 0) fall_edge[i] = ec;
        end
    endtask

    task automatic do_start();
        start = 1'b1; start_edge = ec + 1; tick(1); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(1); abort = 1'b0;
    endtask

    initial begin
        clear_marks();
        tick(2);
        check_val("reset_br", branch_reset, 5'h1f);
        check_val("reset_pend", pending, 5'h1f);
        reset = 1'b1;

        // All acks high: staggered release and done 21 edges after start.
        branch_ack = 5'h1f;
        tick(9);
        clear_marks();
        do_start();
        tick(25);
        for (int i = 0; i < N; i++) check_val("fall_edge", fall_edge[i] - start_edge, (i + 1) * S);
        check_val("done_edge", done_edge - start_edge, 21);
        for (int c = 0; c < 100; c++) begin start = c[0]; tick(1); end
        start = 1'b0;
        check_val("done_hold", done, 1'b1);
        @(posedge clock); #2 reset = 1'b0; #1;
        check_val("async_done_br", branch_reset, 5'h1f);
        check_val("async_done", done, 1'b0);
        tick(2); reset = 1'b1;

        // Branch 3 never acks: timeout after 276 edges with its bit left pending.
        branch_ack = 5'h17;
        clear_marks();
        do_start();
        tick(280);
        check_val("err_edge", err_edge - start_edge, 276);
        check_val("err_pend", pending, 5'h08);
        check_val("err_br", branch_reset, 5'h1f);
        check_val("err_done", done, 1'b0);
        do_abort();

        // Branch 2 ack pulse before release is ignored; one after release sticks.
        branch_ack = 5'h1b;
        do_start();
        tick(4);
        branch_ack[2] = 1'b1; tick(1); branch_ack[2] = 1'b0;
        tick(10);
        check_val("early_pulse", pending[2], 1'b1);
        branch_ack[2] = 1'b1; tick(1); branch_ack[2] = 1'b0;
        tick(1);
        check_val("late_pulse", pending[2], 1'b0);
        tick(10);
        check_val("late_done", done, 1'b1);
        do_abort();

        // Last ack lands exactly on the timeout edge: done wins.
        branch_ack = 5'h17;
        clear_marks();
        do_start();
        while (ec < start_edge + 275) tick(1);
        branch_ack[3] = 1'b1; tick(1); branch_ack[3] = 1'b0;
        tick(1);
        check_val("race_done", done, 1'b1);
        check_val("race_err", timeout_err, 1'b0);
        check_val("race_edge", done_edge - start_edge, 276);
        do_abort();

        // Abort with start after two releases, then a clean restart.
        branch_ack = 5'h00;
        do_start();
        tick(2 * S);
        abort = 1'b1; start = 1'b1; tick(1); abort = 1'b0; start = 1'b0;
        check_val("abort_br", branch_reset, 5'h1f);
        check_val("abort_pend", pending, 5'h1f);
        clear_marks();
        do_start();
        tick(S + 1);
        check_val("restart_fall0", fall_edge[0] - start_edge, S);
        check_val("restart_br", branch_reset, 5'h1e);

        // Async reset in the middle of WAIT.
        tick(N * S);
        @(posedge clock); #2 reset = 1'b0; #1;
        check_val("async_wait_br", branch_reset, 5'h1f);
        check_val("async_wait_done", done, 1'b0);
        tick(3); reset = 1'b1;
        tick(10);
        check_val("post_reset_hold", branch_reset, 5'h1f);

        // Randomized runs with random ack patterns, dead branches and stray aborts.
        for (int r = 0; r < 8; r++) begin
            logic [N-1:0] dead;
            dead = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            do_abort();
            for (int c = 0; c < 320; c++) begin
                branch_ack = N'($urandom) & ~dead;
                start = ($urandom_range(0, 3) == 0);
                abort = ($urandom_range(0, 299) == 0);
                tick(1);
            end
            start = 1'b0; abort = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
